dcache_2way_ctrl: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the pipeline MEM stage and the line-wide data memory.
- Differs from the direct-mapped generation in four ways: configurable line/set geometry, per-set LRU replacement, 32-bit byte-enable writes, and hit/miss performance counters.
- Tag, valid, dirty, LRU and data arrays are internal registers; there is no external SRAM macro.

---
 rtl/dcache_2way_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dcache_2way_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
// All arrays (data, tag, valid, dirty, LRU) are internal registers.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   p1_addr_i           byte address from the pipeline (bits [1:0] ignored)
//   p1_data_i, p1_be_i  store data and byte enables
//   p1_MemRead_i        load request
//   p1_MemWrite_i       store request (wins if both are set)
//   p1_data_o           load data, combinational on hit, 0 otherwise
//   p1_stall_o          request pending and not hitting
//   mem_*               line-wide memory handshake (write-back / refill)
//   hit_cnt_o           completed hits
//   miss_cnt_o          misses entered
module dcache_2way_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned SETS       = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       p1_addr_i,
    input  logic [31:0]             p1_data_i,
    input  logic [3:0]              p1_be_i,
    input  logic                    p1_MemRead_i,
    input  logic                    p1_MemWrite_i,
    output logic [31:0]             p1_data_o,
    output logic                    p1_stall_o,
    input  logic [8*LINE_BYTES-1:0] mem_data_i,
    input  logic                    mem_ack_i,
    output logic [8*LINE_BYTES-1:0] mem_data_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_enable_o,
    output logic                    mem_write_o,
    output logic [CNT_W-1:0]        hit_cnt_o,
    output logic [CNT_W-1:0]        miss_cnt_o
);

    localparam int unsigned LINE_W = 8 * LINE_BYTES;
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WORDS  = LINE_BYTES / 4;
    localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StMiss,
        StWriteback,
        StRefill,
        StRefillOk
    } state_e;

    state_e state_q, state_d;

    // Storage arrays
    logic [LINE_W-1:0]        data_q [2][SETS];
    logic [TAG_W-1:0]         tag_q  [2][SETS];
    logic [1:0][SETS-1:0]     valid_q;
    logic [1:0][SETS-1:0]     dirty_q;
    logic [SETS-1:0]          lru_q;      // way to evict next in each set

    // Miss context latched on entry to StMiss
    logic                     way_q;
    logic [TAG_W-1:0]         tag_lat_q;
    logic [IDX_W-1:0]         idx_lat_q;

    logic [CNT_W-1:0]         hit_cnt_q;
    logic [CNT_W-1:0]         miss_cnt_q;

    // Request decode
    logic                     req;
    logic                     is_store;
    logic [TAG_W-1:0]         req_tag;
    logic [IDX_W-1:0]         req_idx;
    logic [WSEL_W-1:0]        word_sel;
    logic                     unused_addr;

    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign is_store    = p1_MemWrite_i;
    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
    assign unused_addr = ^p1_addr_i[1:0];

    if (WORDS > 1) begin : g_wsel
        assign word_sel = p1_addr_i[2 +: WSEL_W];
    end else begin : g_wsel_single
        assign word_sel = '0;
    end

    // Hit detection and data path
    logic [1:0]               hit_w;
    logic                     hit;
    logic                     hit_way;
    logic [LINE_W-1:0]        hit_line;
    logic [LINE_W-1:0]        wr_line;
    logic [31:0]              hit_word;
    logic                     victim;

    assign hit_w[0] = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit_w[1] = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];  // both ways never hold the same tag

    always_comb begin
        hit_line = data_q[hit_way][req_idx];
        hit_word = hit_line[32*word_sel +: 32];
        wr_line  = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (p1_be_i[b]) begin
                wr_line[32*word_sel + 8*b +: 8] = p1_data_i[8*b +: 8];
            end
        end
    end

    assign p1_data_o  = hit ? hit_word : 32'h0;
    assign p1_stall_o = req & ~hit;

    // Fill invalid ways first (way 0 before way 1), then fall back to LRU.
    always_comb begin
        if (!valid_q[0][req_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][req_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[req_idx];
        end
    end

    // FSM next state and Moore memory outputs
    logic                     miss_start;
    logic                     hit_upd;
    logic                     refill_done;
    logic [ADDR_W-1:0]        wb_addr;
    logic [ADDR_W-1:0]        rf_addr;

    assign wb_addr = {tag_q[way_q][idx_lat_q], idx_lat_q, {OFF_W{1'b0}}};
    assign rf_addr = {tag_lat_q, idx_lat_q, {OFF_W{1'b0}}};

    always_comb begin
        state_d      = state_q;
        miss_start   = 1'b0;
        hit_upd      = 1'b0;
        refill_done  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit) begin
                        hit_upd = 1'b1;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = StMiss;
                    end
                end
            end
            StMiss: begin
                if (valid_q[way_q][idx_lat_q] && dirty_q[way_q][idx_lat_q]) begin
                    state_d = StWriteback;
                end else begin
                    state_d = StRefill;
                end
            end
            StWriteback: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = wb_addr;
                mem_data_o   = data_q[way_q][idx_lat_q];
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = rf_addr;
                if (mem_ack_i) begin
                    refill_done = 1'b1;
                    state_d     = StRefillOk;
                end
            end
            StRefillOk: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            way_q      <= 1'b0;
            tag_lat_q  <= '0;
            idx_lat_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                way_q      <= victim;
                tag_lat_q  <= req_tag;
                idx_lat_q  <= req_idx;
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
            if (hit_upd) begin
                lru_q[req_idx] <= ~hit_way;
                hit_cnt_q      <= hit_cnt_q + CNT_W'(1);
                if (is_store) begin
                    dirty_q[hit_way][req_idx] <= 1'b1;
                end
            end
            if (refill_done) begin
                valid_q[way_q][idx_lat_q] <= 1'b1;
                dirty_q[way_q][idx_lat_q] <= 1'b0;
            end
        end
    end

    // Data and tag arrays carry no reset; valid bits gate their contents.
    always_ff @(posedge clk_i) begin
        if (hit_upd && is_store) begin
            data_q[hit_way][req_idx] <= wr_line;
        end
        if (refill_done) begin
            data_q[way_q][idx_lat_q] <= mem_data_i;
            tag_q[way_q][idx_lat_q]  <= tag_lat_q;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Self-checking bench for dcache_2way_ctrl with default geometry
// (32-byte lines, 32 sets). A behavioural line memory answers transactions
// with a programmable ack delay and logs every transaction it sees.
module tb_dcache_2way_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic [3:0]        p1_be_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [CNT_W-1:0]  hit_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    dcache_2way_ctrl #(
        .ADDR_W     (32),
        .LINE_BYTES (32),
        .SETS       (32),
        .CNT_W      (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_be_i       (p1_be_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_line(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural line memory and transaction log
    typedef struct {
        logic [31:0]       addr;
        logic              wr;
        logic [LINE_W-1:0] data;
    } txn_t;

    txn_t              log_q[$];
    logic [LINE_W-1:0] mem [0:127];
    int                ack_delay  = 0;
    bit                inject_ack = 1'b0;
    int                stab_err   = 0;

    initial begin
        bit                active;
        int                cnt;
        logic [31:0]       t_addr;
        logic              t_wr;
        logic [LINE_W-1:0] t_data;
        txn_t              t;
        active     = 1'b0;
        cnt        = 0;
        t_addr     = '0;
        t_wr       = 1'b0;
        t_data     = '0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                active    = 1'b0;
            end
            if (!rst_i) begin
                active = 1'b0;
            end else if (inject_ack) begin
                mem_ack_i  = 1'b1;
                inject_ack = 1'b0;
            end else if (mem_enable_o) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    t_addr = mem_addr_o;
                    t_wr   = mem_write_o;
                    t_data = mem_data_o;
                    t.addr = t_addr;
                    t.wr   = t_wr;
                    t.data = t_data;
                    log_q.push_back(t);
                end else if (mem_addr_o !== t_addr || mem_write_o !== t_wr ||
                             (t_wr && mem_data_o !== t_data)) begin
                    stab_err++;
                end
                if (cnt == ack_delay) begin
                    mem_ack_i = 1'b1;
                    if (t_wr) mem[t_addr[11:5]] = t_data;
                    else      mem_data_i = mem[t_addr[11:5]];
                end else begin
                    cnt++;
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    task automatic idle_inputs();
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        p1_be_i       = 4'h0;
        p1_data_i     = 32'h0;
    endtask

    task automatic drive(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] be);
        p1_addr_i     = addr;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_data_i     = wdata;
        p1_be_i       = be;
    endtask

    // Single-cycle hit in IDLE; exp_data is the word before any merge.
    task automatic hit_access(input string name, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_data);
        @(negedge clk_i);
        drive(addr, ~wr, wr, wdata, be);
        #1;
        check32({name, "_stall"}, {31'h0, p1_stall_o}, 32'h0);
        check32({name, "_data"}, p1_data_o, exp_data);
        @(negedge clk_i);
        idle_inputs();
    endtask

    // Miss: counts cycles with stall high, then holds the request through
    // REFILLOK and the IDLE hit edge before dropping it.
    task automatic miss_access(input string name, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [3:0] be, input int delay,
                               input logic [31:0] exp_data, input int exp_cycles);
        int cyc;
        bit done;
        ack_delay = delay;
        @(negedge clk_i);
        drive(addr, ~wr, wr, wdata, be);
        #1;
        check32({name, "_stall_first"}, {31'h0, p1_stall_o}, 32'h1);
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk_i);
            #1;
            if (!p1_stall_o) done = 1'b1;
            else cyc++;
        end
        check32({name, "_stall_cycles"}, cyc, exp_cycles);
        check32({name, "_data"}, p1_data_o, exp_data);
        repeat (2) @(negedge clk_i);
        idle_inputs();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [11];

    logic [LINE_W-1:0] exp_wb_400;
    logic [LINE_W-1:0] exp_wb_000;
    bit                seen;

    initial begin
        // Hit vectors over set 0 once it holds lines 0x000 and 0x400
        vecs[0]  = '{32'h000, 1'b1, 1'b0, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[1]  = '{32'h404, 1'b1, 1'b0, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[2]  = '{32'h800, 1'b0, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[3]  = '{32'h008, 1'b0, 1'b1, 32'h55667788, 4'hF, 32'h12345678, 1'b0};
        vecs[4]  = '{32'h008, 1'b1, 1'b0, 32'h0,        4'h0, 32'h55667788, 1'b0};
        vecs[5]  = '{32'h008, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h55667788, 1'b0};
        vecs[6]  = '{32'h008, 1'b1, 1'b0, 32'h0,        4'h0, 32'h55667788, 1'b0};
        vecs[7]  = '{32'h41C, 1'b0, 1'b1, 32'hA5A5A5A5, 4'h8, 32'h00000000, 1'b0};
        vecs[8]  = '{32'h41C, 1'b1, 1'b0, 32'h0,        4'h0, 32'hA5000000, 1'b0};
        vecs[9]  = '{32'h403, 1'b1, 1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{32'h41C, 1'b0, 1'b0, 32'h0,        4'h0, 32'hA5000000, 1'b0};

        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[0]  = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'hCAFEF00D};
        mem[32] = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'hDEADBEEF};
        mem[64] = {32'h77777777, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0BADC0DE};
        mem[96] = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC0C0C0C0};
        exp_wb_400 = {32'hA5000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11BB33DD,
                      32'h99999999};
        exp_wb_000 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h55667788, 32'h0, 32'hCAFEF00D};

        rst_i     = 1'b0;
        p1_addr_i = '0;
        idle_inputs();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check32("rst_enable", {31'h0, mem_enable_o}, 32'h0);
        check32("rst_write", {31'h0, mem_write_o}, 32'h0);
        check32("rst_hit_cnt", hit_cnt_o, 32'h0);
        check32("rst_miss_cnt", miss_cnt_o, 32'h0);
        check32("rst_stall", {31'h0, p1_stall_o}, 32'h0);

        // Cold read
        miss_access("cold", 32'h400, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 3);
        check32("cold_log_size", log_q.size(), 1);
        check32("cold_addr", log_q[0].addr, 32'h400);
        check32("cold_wr", {31'h0, log_q[0].wr}, 32'h0);
        check32("cold_miss_cnt", miss_cnt_o, 1);
        check32("cold_hit_cnt", hit_cnt_o, 1);

        // Byte-enable store
        hit_access("be_store", 32'h404, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h11223344);
        hit_access("be_read", 32'h404, 1'b0, 32'h0, 4'h0, 32'h11BB33DD);

        // Associativity within set 0
        miss_access("assoc0", 32'h000, 1'b0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 3);
        hit_access("assoc1", 32'h400, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF);
        hit_access("assoc2", 32'h000, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D);
        check32("assoc_log_size", log_q.size(), 2);
        check32("assoc_addr", log_q[1].addr, 32'h000);
        check32("assoc_wr", {31'h0, log_q[1].wr}, 32'h0);
        check32("assoc_miss_cnt", miss_cnt_o, 2);

        // Table of back-to-back hits
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            drive(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].be);
            #1;
            check32($sformatf("vec%0d_data", i), p1_data_o, vecs[i].exp_data);
            check32($sformatf("vec%0d_stall", i), {31'h0, p1_stall_o}, {31'h0, vecs[i].exp_stall});
        end
        @(negedge clk_i);
        idle_inputs();
        check32("vec_hit_cnt", hit_cnt_o, 15);

        // LRU choice and dirty eviction
        hit_access("lru_store", 32'h400, 1'b1, 32'h99999999, 4'hF, 32'hDEADBEEF);
        hit_access("lru_read", 32'h000, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D);
        miss_access("evict", 32'h800, 1'b0, 32'h0, 4'h0, 0, 32'h0BADC0DE, 4);
        check32("evict_log_size", log_q.size(), 4);
        check32("evict_wb_addr", log_q[2].addr, 32'h400);
        check32("evict_wb_wr", {31'h0, log_q[2].wr}, 32'h1);
        check_line("evict_wb_data", log_q[2].data, exp_wb_400);
        check32("evict_rf_addr", log_q[3].addr, 32'h800);
        check32("evict_rf_wr", {31'h0, log_q[3].wr}, 32'h0);
        check32("evict_miss_cnt", miss_cnt_o, 3);
        check32("evict_hit_cnt", hit_cnt_o, 18);

        // Memory latency on dirty and clean misses
        miss_access("lat1", 32'h400, 1'b0, 32'h0, 4'h0, 1, 32'h99999999, 6);
        check32("lat1_wb_addr", log_q[4].addr, 32'h000);
        check_line("lat1_wb_data", log_q[4].data, exp_wb_000);
        check32("lat1_rf_addr", log_q[5].addr, 32'h400);
        miss_access("lat7", 32'hC00, 1'b0, 32'h0, 4'h0, 7, 32'hC0C0C0C0, 10);
        check32("lat7_log_size", log_q.size(), 7);
        check32("lat7_rf_addr", log_q[6].addr, 32'hC00);
        check32("lat7_rf_wr", {31'h0, log_q[6].wr}, 32'h0);
        check32("lat_stable", stab_err, 0);
        check32("lat_miss_cnt", miss_cnt_o, 5);

        // Reset in the middle of a refill
        ack_delay = 1000;
        @(negedge clk_i);
        drive(32'h000, 1'b1, 1'b0, 32'h0, 4'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            #1;
            if (mem_enable_o) seen = 1'b1;
        end
        check32("mid_enable", {31'h0, mem_enable_o}, 32'h1);
        check32("mid_addr", mem_addr_o, 32'h000);
        check32("mid_write", {31'h0, mem_write_o}, 32'h0);
        #2 rst_i = 1'b0;
        #1;
        check32("mid_rst_enable", {31'h0, mem_enable_o}, 32'h0);
        check32("mid_rst_stall", {31'h0, p1_stall_o}, 32'h1);
        check32("mid_rst_hit_cnt", hit_cnt_o, 0);
        check32("mid_rst_miss_cnt", miss_cnt_o, 0);
        @(negedge clk_i);
        idle_inputs();
        rst_i     = 1'b1;
        ack_delay = 0;
        #2 inject_ack = 1'b1;
        repeat (3) @(negedge clk_i);
        p1_addr_i = 32'h400;
        #1;
        check32("late_ack_enable", {31'h0, mem_enable_o}, 32'h0);
        check32("late_ack_miss_cnt", miss_cnt_o, 0);
        check32("invalid_data", p1_data_o, 32'h0);
        miss_access("reread", 32'h000, 1'b0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 3);
        check32("reread_miss_cnt", miss_cnt_o, 1);
        check32("reread_hit_cnt", hit_cnt_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit with no summary, required run to finish");
        $fatal(1);
    end

endmodule
